tmp_adc_ctrl: RTL and testbench

- Conversion controller on the ADC side of the temperature sensor path.
- Periodically triggers the temperature ADC and handshakes on end-of-conversion. Averages 2^AVG_LOG2 samples and holds the result on data_out.
- data_out feeds the CPU-readable temperature register's data_in.
- Supervises the ADC with a conversion timeout and a sticky error flag.

---
 rtl/tmp_adc_ctrl_pkg.sv | 18 +
 rtl/tmp_avg_acc.sv | 42 ++++
 rtl/tmp_adc_ctrl.sv | 127 ++++++++++++
 tb/tb_tmp_adc_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_adc_ctrl_pkg.sv
// Shared definitions for the temperature-sensor ADC conversion controller:
// FSM state encoding and default build parameters.
package tmp_adc_ctrl_pkg;

   localparam int DEF_ADC_RES  = 10;
   localparam int DEF_PERIOD_W = 16;
   localparam int DEF_AVG_LOG2 = 2;
   localparam int DEF_TIMEOUT  = 255;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_START = 3'd2,
      ST_CONV  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/tmp_avg_acc.sv
// Sample accumulator and sample counter for the ADC averaging path.
// sum is the running total including the sample currently presented.
module tmp_avg_acc
   import tmp_adc_ctrl_pkg::*;
#(
   parameter int ADC_RES  = DEF_ADC_RES,
   parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        add,
   input  logic [ADC_RES-1:0]          sample,
   output logic [ADC_RES+AVG_LOG2-1:0] sum,
   output logic                        done
);

   localparam int ACC_W = ADC_RES + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;

   // done flags that an add in this cycle completes the set
   assign sum  = acc + ACC_W'(sample);
   assign done = (count == LAST_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
      end else if (clr) begin
         acc   <= '0;
         count <= '0;
      end else if (add) begin
         acc   <= sum;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tmp_adc_ctrl.sv
// Periodic ADC trigger with end-of-conversion handshake, 2^AVG_LOG2 sample
// averaging, conversion timeout supervision and a sticky timeout flag.
module tmp_adc_ctrl
   import tmp_adc_ctrl_pkg::*;
#(
   parameter int ADC_RES  = DEF_ADC_RES,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                adc_start,
   input  logic                adc_eoc,
   input  logic [ADC_RES-1:0]  adc_dout,
   output logic [ADC_RES-1:0]  data_out,
   output logic                data_valid,
   output logic                timeout_err,
   input  logic                err_clr
);

   localparam int ACC_W = ADC_RES + AVG_LOG2;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t              state;
   logic [PERIOD_W-1:0] per_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [ACC_W-1:0]    sum;
   logic                last;
   logic                tmo_hit;
   logic                acc_add;
   logic                acc_clr;

   function automatic logic [ADC_RES-1:0] trunc_avg(input logic [ACC_W-1:0] s);
      logic [ACC_W-1:0] sh;
      sh = s >> AVG_LOG2;
      return sh[ADC_RES-1:0];
   endfunction

   // eoc on the expiry cycle wins, so a hit requires eoc low
   assign tmo_hit = (state == ST_CONV) && !adc_eoc && (tmo_cnt == TMO_W'(1));
   assign acc_add = en && (state == ST_CONV) && adc_eoc;
   assign acc_clr = !en || (state == ST_DONE) || tmo_hit;

   tmp_avg_acc #(
      .ADC_RES  (ADC_RES),
      .AVG_LOG2 (AVG_LOG2)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .add    (acc_add),
      .sample (adc_dout),
      .sum    (sum),
      .done   (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         per_cnt     <= '0;
         tmo_cnt     <= '0;
         adc_start   <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         adc_start  <= 1'b0;
         data_valid <= 1'b0;
         // a timeout set later in this block overrides the clear
         if (err_clr)
            timeout_err <= 1'b0;
         if (!en) begin
            state   <= ST_IDLE;
            per_cnt <= '0;
            tmo_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state     <= ST_START;
                  adc_start <= 1'b1;
               end
               ST_WAIT: begin
                  if (per_cnt == '0) begin
                     state     <= ST_START;
                     adc_start <= 1'b1;
                  end else begin
                     per_cnt <= per_cnt - 1'b1;
                  end
               end
               ST_START: begin
                  tmo_cnt <= TMO_W'(TIMEOUT);
                  state   <= ST_CONV;
               end
               ST_CONV: begin
                  if (adc_eoc) begin
                     tmo_cnt <= '0;
                     if (last) begin
                        data_out   <= trunc_avg(sum);
                        data_valid <= 1'b1;
                        state      <= ST_DONE;
                     end else begin
                        per_cnt <= period;
                        state   <= ST_WAIT;
                     end
                  end else if (tmo_hit) begin
                     timeout_err <= 1'b1;
                     tmo_cnt     <= '0;
                     per_cnt     <= period;
                     state       <= ST_WAIT;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                  end
               end
               ST_DONE: begin
                  per_cnt <= period;
                  state   <= ST_WAIT;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tmp_adc_ctrl.sv
// Bench for tmp_adc_ctrl: an ADC stand-in answers adc_start, a sample-list
// model predicts averages and start timing, and a monitor scores data_valid.
module tb_tmp_adc_ctrl;

   localparam int ADC_RES  = 10;
   localparam int PERIOD_W = 16;
   localparam int AVG_LOG2 = 2;
   localparam int TIMEOUT  = 255;
   localparam int NAVG     = 1 << AVG_LOG2;

   logic                clk      = 1'b0;
   logic                rst      = 1'b0;
   logic                en       = 1'b0;
   logic                adc_eoc  = 1'b0;
   logic                err_clr  = 1'b0;
   logic [PERIOD_W-1:0] period   = '0;
   logic [ADC_RES-1:0]  adc_dout = '0;
   logic                adc_start;
   logic                data_valid;
   logic                timeout_err;
   logic [ADC_RES-1:0]  data_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int samples[$];
   int exp_val_q[$];
   int exp_cyc_q[$];
   int exp_start = 0;
   int exp_err   = 0;
   int last_val  = 0;
   int tr[4] = '{0, 0, 0, 3};
   bit rgot;

   tmp_adc_ctrl #(
      .ADC_RES  (ADC_RES),
      .PERIOD_W (PERIOD_W),
      .AVG_LOG2 (AVG_LOG2),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .period      (period),
      .adc_start   (adc_start),
      .adc_eoc     (adc_eoc),
      .adc_dout    (adc_dout),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: every data_valid pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (data_valid) begin
         if (exp_val_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: actual data_out=%0d required=no pulse (cycle %0d)",
                     data_out, cyc);
         end else begin
            chk("data_out", int'(data_out), exp_val_q.pop_front());
            chk("valid_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
   end

   // Reference model: average of the last NAVG accepted samples, next start
   // period+1 cycles after leaving the conversion (one more when a result completes).
   task automatic model_accept(input int s, input int t);
      int acc_sum;
      samples.push_back(s);
      if (samples.size() == NAVG) begin
         acc_sum = 0;
         foreach (samples[i]) acc_sum += samples[i];
         last_val = acc_sum / NAVG;
         exp_val_q.push_back(last_val);
         exp_cyc_q.push_back(t + 1);
         samples.delete();
         exp_start = t + int'(period) + 3;
      end else begin
         exp_start = t + int'(period) + 2;
      end
   endtask

   task automatic wait_start(output bit got);
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (adc_start) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // One conversion: eoc d cycles after the start pulse, or none if d > TIMEOUT.
   task automatic do_conv(input int d, input int s, input bit stretch, input bit clr_exp);
      bit got;
      int st;
      wait_start(got);
      chk("start_seen", int'(got), 1);
      if (got) begin
         st = cyc;
         chk("start_time", st, exp_start);
         @(negedge clk);
         chk("start_pulse", int'(adc_start), 0);
         if (d <= TIMEOUT) begin
            repeat (d - 1) @(negedge clk);
            adc_eoc  = 1'b1;
            adc_dout = ADC_RES'(s);
            model_accept(s, st + d);
            @(negedge clk);
            if (stretch) adc_dout = ADC_RES'($urandom);
            else adc_eoc = 1'b0;
            @(negedge clk);
            adc_eoc = 1'b0;
            chk("err_after_eoc", int'(timeout_err), exp_err);
         end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            chk("err_before_expiry", int'(timeout_err), exp_err);
            err_clr = clr_exp;
            @(negedge clk);
            err_clr = 1'b0;
            samples.delete();
            exp_err   = 1;
            exp_start = st + TIMEOUT + int'(period) + 2;
            chk("err_at_expiry", int'(timeout_err), exp_err);
         end
      end
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_err = 0;
      chk("err_cleared", int'(timeout_err), exp_err);
   endtask

   task automatic drop_en(input int n);
      en = 1'b0;
      samples.delete();
      repeat (n) @(negedge clk);
      chk("hold_data", int'(data_out), last_val);
      chk("idle_no_start", int'(adc_start), 0);
      en = 1'b1;
      exp_start = cyc + 1;
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_adc_start", int'(adc_start), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_data_valid", int'(data_valid), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_start", int'(adc_start), 0);

      period = 16'd3;
      en = 1'b1;
      exp_start = cyc + 1;
      for (int i = 0; i < 4; i++) do_conv(5, 100 + i, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_conv(3, 1023, i[0], 1'b0);
      for (int i = 0; i < 4; i++) do_conv(2 + i, tr[i], 1'b1, 1'b0);

      // eoc on the final allowed cycle is accepted
      do_conv(TIMEOUT, 7, 1'b0, 1'b0);
      do_conv(4, 9, 1'b0, 1'b0);
      do_conv(1, 11, 1'b0, 1'b0);
      do_conv(6, 13, 1'b0, 1'b0);

      do_conv(TIMEOUT + 1, 0, 1'b0, 1'b0);
      clear_err();
      do_conv(5, 500, 1'b0, 1'b0);
      do_conv(5, 600, 1'b0, 1'b0);
      do_conv(TIMEOUT + 1, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) do_conv(3, 40 + 10 * i, 1'b0, 1'b0);

      do_conv(3, 900, 1'b0, 1'b0);
      do_conv(3, 901, 1'b0, 1'b0);
      drop_en(4);
      do_conv(3, 200, 1'b0, 1'b0);
      do_conv(4, 300, 1'b0, 1'b0);
      do_conv(2, 400, 1'b0, 1'b0);
      do_conv(5, 501, 1'b0, 1'b0);

      // asynchronous reset in the middle of a conversion
      wait_start(rgot);
      chk("start_seen", int'(rgot), 1);
      chk("start_time", cyc, exp_start);
      chk("pre_rst_data", int'(data_out), last_val);
      chk("pre_rst_err", int'(timeout_err), exp_err);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_adc_start", int'(adc_start), 0);
      chk("arst_data_out", int'(data_out), 0);
      chk("arst_data_valid", int'(data_valid), 0);
      chk("arst_timeout_err", int'(timeout_err), 0);
      @(negedge clk);
      rst = 1'b0;
      samples.delete();
      exp_err   = 0;
      last_val  = 0;
      exp_start = cyc + 1;
      for (int i = 0; i < 4; i++) do_conv(2, 1000 - 7 * i, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin : rnd
         int d;
         int s;
         period = PERIOD_W'($urandom_range(0, 4));
         if ($urandom_range(0, 11) == 0) d = TIMEOUT + 1;
         else d = int'($urandom_range(1, 8));
         s = int'($urandom_range(0, (1 << ADC_RES) - 1));
         do_conv(d, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (d > TIMEOUT && $urandom_range(0, 1) == 1) clear_err();
         if ($urandom_range(0, 14) == 0) drop_en(int'($urandom_range(1, 3)));
      end

      repeat (5) @(negedge clk);
      chk("pending_results", exp_val_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
